// File: rtl/vmc_pkg.sv
// Shared definitions for the vending machine controller and its change dispenser.
package vmc_pkg;

    localparam int unsigned CHANGE_W_DEF = 4;

    localparam int unsigned COIN_1 = 1;
    localparam int unsigned COIN_2 = 2;
    localparam int unsigned COIN_5 = 5;

    typedef enum logic [2:0] {
        DISP_IDLE     = 3'd0,
        DISP_SELECT   = 3'd1,
        DISP_EJECT    = 3'd2,
        DISP_WAIT_ACK = 3'd3,
        DISP_DONE     = 3'd4,
        DISP_FAULT    = 3'd5
    } disp_state_t;

    // One-hot coin choice, one bit per hopper.
    typedef struct packed {
        logic c5;
        logic c2;
        logic c1;
    } coin_sel_t;

    // Rupee value of a one-hot coin choice (0 when nothing is selected).
    function automatic int unsigned coin_value(input coin_sel_t sel);
        int unsigned v;
        v = 0;
        if (sel.c5) begin
            v = COIN_5;
        end else if (sel.c2) begin
            v = COIN_2;
        end else if (sel.c1) begin
            v = COIN_1;
        end
        return v;
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy largest-first coin picker that skips empty hoppers.
module change_coin_select
    import vmc_pkg::*;
#(
    parameter int unsigned CHANGE_W = CHANGE_W_DEF
) (
    input  logic [CHANGE_W-1:0] remaining,
    input  logic                hopper_empty_5,
    input  logic                hopper_empty_2,
    input  logic                hopper_empty_1,
    output coin_sel_t           coin_sel,
    output logic                none_eligible
);

    logic [31:0] w_rem32;
    logic        w_ok5;
    logic        w_ok2;
    logic        w_ok1;

    // A coin is eligible only if its value fits in what is still owed.
    always_comb begin
        w_rem32        = 32'(remaining);
        w_ok5          = !hopper_empty_5 && (w_rem32 >= 32'(COIN_5));
        w_ok2          = !hopper_empty_2 && (w_rem32 >= 32'(COIN_2));
        w_ok1          = !hopper_empty_1 && (w_rem32 >= 32'(COIN_1));
        coin_sel       = '0;
        coin_sel.c5    = w_ok5;
        coin_sel.c2    = !w_ok5 && w_ok2;
        coin_sel.c1    = !w_ok5 && !w_ok2 && w_ok1;
        none_eligible  = !(w_ok5 || w_ok2 || w_ok1);
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as timed, acknowledged Rs 5 / 2 / 1 ejector pulses.
module change_dispenser
    import vmc_pkg::*;
#(
    parameter int unsigned CHANGE_W     = CHANGE_W_DEF,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                change_valid,
    input  logic [CHANGE_W-1:0] change_amt,
    input  logic                hopper_empty_5,
    input  logic                hopper_empty_2,
    input  logic                hopper_empty_1,
    input  logic                eject_done,
    output logic                eject_5,
    output logic                eject_2,
    output logic                eject_1,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [CHANGE_W-1:0] remaining
);

    localparam int unsigned PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    disp_state_t         r_state;
    disp_state_t         w_state_nxt;
    logic [CHANGE_W-1:0] r_rem;
    logic [CHANGE_W-1:0] w_rem_nxt;
    coin_sel_t           r_coin;
    coin_sel_t           w_coin_nxt;
    logic [PC_W-1:0]     r_pcnt;
    logic [PC_W-1:0]     w_pcnt_nxt;
    logic [TO_W-1:0]     r_tcnt;
    logic [TO_W-1:0]     w_tcnt_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    coin_sel_t           r_eject;
    coin_sel_t           w_eject_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    coin_sel_t           w_sel;
    logic                w_none;

    change_coin_select #(
        .CHANGE_W (CHANGE_W)
    ) u_select (
        .remaining      (r_rem),
        .hopper_empty_5 (hopper_empty_5),
        .hopper_empty_2 (hopper_empty_2),
        .hopper_empty_1 (hopper_empty_1),
        .coin_sel       (w_sel),
        .none_eligible  (w_none)
    );

    // State, counters and registered outputs; reset drops any ejector pulse at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DISP_IDLE;
            r_rem   <= '0;
            r_coin  <= '0;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
            r_fault <= 1'b0;
            r_eject <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_coin  <= w_coin_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_fault <= w_fault_nxt;
            r_eject <= w_eject_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_coin_nxt  = r_coin;
        w_pcnt_nxt  = r_pcnt;
        w_tcnt_nxt  = r_tcnt;
        w_fault_nxt = r_fault;

        case (r_state)
            DISP_IDLE: begin
                if (change_valid) begin
                    w_rem_nxt   = change_amt;
                    w_fault_nxt = 1'b0;
                    w_state_nxt = DISP_SELECT;
                end
            end
            DISP_SELECT: begin
                if (r_rem == '0) begin
                    w_state_nxt = DISP_DONE;
                end else if (w_none) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = DISP_FAULT;
                end else begin
                    w_coin_nxt  = w_sel;
                    w_pcnt_nxt  = '0;
                    w_state_nxt = DISP_EJECT;
                end
            end
            DISP_EJECT: begin
                if (r_pcnt == PC_W'(PULSE_CYCLES - 1)) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = DISP_WAIT_ACK;
                end else begin
                    w_pcnt_nxt = r_pcnt + PC_W'(1);
                end
            end
            DISP_WAIT_ACK: begin
                // An ack on the expiry cycle still credits the coin.
                if (eject_done) begin
                    w_rem_nxt   = r_rem - CHANGE_W'(coin_value(r_coin));
                    w_state_nxt = DISP_SELECT;
                end else if (r_tcnt == TO_W'(ACK_TIMEOUT)) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = DISP_FAULT;
                end else begin
                    w_tcnt_nxt = r_tcnt + TO_W'(1);
                end
            end
            DISP_DONE: begin
                w_state_nxt = DISP_IDLE;
            end
            DISP_FAULT: begin
                w_state_nxt = DISP_IDLE;
            end
            default: begin
                w_state_nxt = DISP_IDLE;
            end
        endcase

        w_eject_nxt = (w_state_nxt == DISP_EJECT) ? w_coin_nxt : '0;
        w_busy_nxt  = (w_state_nxt != DISP_IDLE);
        w_done_nxt  = (w_state_nxt == DISP_DONE);
    end

    assign eject_5   = r_eject.c5;
    assign eject_2   = r_eject.c2;
    assign eject_1   = r_eject.c1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign remaining = r_rem;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout-side companion to the vending machine controller. It accepts a change amount strobed by the controller and pays it out as physical coins. It breaks the amount into Rs 5 / Rs 2 / Rs 1 coins, largest first, skipping empty hoppers. Each coin is one timed ejector pulse, acknowledged by the hopper mechanism, before the next coin is issued. It sits between the controller's `Change` output and the coin hopper hardware.

## Interface
Parameters:
- `CHANGE_W`, default 4: width of the change amount in rupees.
- `PULSE_CYCLES`, default 2: ejector pulse width in clock cycles (≥1).
- `ACK_TIMEOUT`, default 255: maximum cycles to wait for `eject_done` after a pulse ends.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `change_valid` in 1: one-cycle strobe; `change_amt` is valid in that cycle.
- `change_amt` in CHANGE_W: change to pay, in rupees.
- `hopper_empty_5`, `hopper_empty_2`, `hopper_empty_1` in 1 each: hopper has no coins of that value.
- `eject_done` in 1: hopper acknowledges one coin physically released.
- `eject_5`, `eject_2`, `eject_1` out 1 each: ejector drive; at most one is high at a time.
- `busy` out 1: a payout is in progress.
- `done` out 1: one-cycle pulse when a payout completes successfully.
- `fault` out 1: level; the payout was abandoned.
- `remaining` out CHANGE_W: rupees still unpaid.

## Operation
- FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
- **IDLE**
  - `change_valid`=1 → load `remaining`=`change_amt`, clear `fault`, go to SELECT.
  - This is the only state where `change_valid` is accepted; strobes in any other state are dropped, not queued.
- **SELECT** (one cycle): greedy pick.
  - Coin = 5 if `remaining`≥5 and the Rs 5 hopper is not empty.
  - Else 2 if `remaining`≥2 and the Rs 2 hopper is not empty.
  - Else 1 if `remaining`≥1 and the Rs 1 hopper is not empty.
  - `remaining`=0 → DONE. No eligible coin with `remaining`>0 → FAULT. Otherwise latch the coin and go to EJECT.
  - Hopper-empty inputs are sampled only in SELECT.
- **EJECT**: drive the selected `eject_x` high for exactly PULSE_CYCLES cycles, then go to WAIT_ACK.
- **WAIT_ACK**
  - `eject_done` is sampled only in this state. On `eject_done`: `remaining` -= coin value, go to SELECT.
  - If the timeout counter reaches ACK_TIMEOUT → FAULT, with `remaining` unchanged (that coin is not credited).
- **DONE**: `done`=1 for one cycle, then IDLE.
- **FAULT**: `fault`=1 and `remaining` holds the unpaid amount.
  - Exits to IDLE on the next cycle. `fault` and `remaining` stay held until the next accepted `change_valid` or reset.
- `busy` = state ∉ {IDLE}; it is high in DONE and low in IDLE and after the FAULT cycle.
- Arithmetic: `remaining` never underflows, because a coin is chosen only if its value ≤ `remaining`. `change_amt`=0 is legal and produces `done` with no ejection.

## Timing
- All outputs reset to 0. State resets to IDLE. The timeout counter resets to 0.
- Reset assertion mid-payout immediately drops any ejector pulse. No partial credit is retained.
- `change_valid` at cycle N → SELECT at N+1 → first `eject_x` high at N+2…N+1+PULSE_CYCLES.
- `eject_done` at cycle M in WAIT_ACK → SELECT at M+1 → next `eject_x` at M+2.
- Last ack at M → DONE (`done`=1) at M+2 → IDLE at M+3.
- Zero amount: `done` at N+2.
- Timeout counter starts at 0 on entry to WAIT_ACK. FAULT is entered on the cycle after the counter reaches ACK_TIMEOUT with no `eject_done`.
- `eject_done` asserted in the same cycle as the timeout expiry is accepted as the ack (ack wins).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `vmc_pkg`:
  - coin value constants COIN_1=1, COIN_2=2, COIN_5=5;
  - dispenser state enum;
  - CHANGE_W default, shared with the controller's `Change` width.
- One sub-module: `change_coin_select`, the combinational greedy picker.
  - Inputs: `remaining` and the three hopper-empty flags.
  - Outputs: one-hot coin select plus `none_eligible`.
- FSM, pulse counter and timeout counter stay in `change_dispenser`.

## Test plan
- `change_amt`=8, all hoppers stocked, ack 3 cycles after each pulse → pulses on `eject_5`, `eject_2`, `eject_1` in that order, then `done` pulse, `remaining`=0, `fault`=0.
- `change_amt`=0 → `done` at N+2, no `eject_x` ever high, `busy` high for exactly 2 cycles.
- `change_amt`=7, `hopper_empty_5`=1 → pulses 2, 2, 2, 1 in order, then `done`.
- `change_amt`=3, `hopper_empty_2`=`hopper_empty_1`=1 → no ejection, `fault`=1, `remaining`=3 held until the next `change_valid`.
- ACK_TIMEOUT=16, `change_amt`=5, `eject_done` held low → `fault` after timeout with `remaining`=5. Separately, `eject_done` landing on the expiry cycle → ack wins and `done` follows.
- `rst` low during WAIT_ACK → all outputs 0 asynchronously, FSM in IDLE. Also: `change_valid`=9 strobed while busy is ignored, and the original payout completes unchanged.
